// File: rtl/delay_pkg.sv
// Shared types and helpers for the echo delay-line sequencer.
// The state set includes CLEAR, which is used only when DELAY_CLEAR_EN is defined.
package delay_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_FB_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_CAP   = 3'd2,
        ST_MUL   = 3'd3,
        ST_WR    = 3'd4,
        ST_DONE  = 3'd5,
        ST_CLEAR = 3'd6
    } state_t;

    // Memory word carries one guard bit above the audio sample.
    function automatic int word_w(input int data_w);
        return data_w + 1;
    endfunction

    function automatic logic signed [16:0] sat17(input logic signed [18:0] x);
        if (x > 19'sd65535)
            return 17'sd65535;
        else if (x < -19'sd65536)
            return -17'sd65536;
        else
            return x[16:0];
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [16:0] x);
        if (x > 17'sd32767)
            return 16'sd32767;
        else if (x < -17'sd32768)
            return -16'sd32768;
        else
            return x[15:0];
    endfunction

endpackage

// File: rtl/delay_sat.sv
// Signed saturator: clamps an IN_W-bit two's-complement value into OUT_W bits.
module delay_sat #(
    parameter int IN_W  = 19,
    parameter int OUT_W = 17
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    localparam logic signed [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};

    // Value fits when every bit from the output sign bit upward agrees.
    logic [IN_W-OUT_W:0] hi;
    assign hi = din[IN_W-1:OUT_W-1];

    always_comb begin
        if (hi == '0 || hi == '1)
            dout = din[OUT_W-1:0];
        else if (din[IN_W-1])
            dout = MINV;
        else
            dout = MAXV;
    end

endmodule

// File: rtl/delay_line_ctrl.sv
// Echo delay-line sequencer: one read/scale/add/write pass per sample strobe over an external BRAM.
// Define DELAY_CLEAR_EN to zero the whole memory after every reset before accepting samples.
module delay_line_ctrl
    import delay_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int FB_W   = DEF_FB_W
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     SAMPLE_STB,
    input  logic signed [DATA_W-1:0] IN_SAMPLE,
    input  logic        [ADDR_W-1:0] DELAY_LEN,
    input  logic        [FB_W-1:0]   FB_GAIN,
    output logic        [ADDR_W-1:0] MEM_ADDR,
    output logic        [DATA_W:0]   MEM_DI,
    output logic                     MEM_WE,
    input  logic        [DATA_W:0]   MEM_DO,
    output logic signed [DATA_W-1:0] OUT_SAMPLE,
    output logic                     OUT_VALID,
    output logic                     BUSY,
    output logic                     OVERRUN
);

    localparam int WORD_W = word_w(DATA_W);
    localparam int PROD_W = WORD_W + FB_W + 1;

    state_t                    state;
    logic        [ADDR_W-1:0]  wr_ptr;
    logic signed [DATA_W-1:0]  in_q;
    logic        [FB_W-1:0]    gain_q;
    logic signed [WORD_W-1:0]  d_q;
    logic signed [PROD_W-1:0]  prod;
    logic signed [WORD_W:0]    fbp;
    logic signed [WORD_W+1:0]  sum;
    logic signed [WORD_W-1:0]  wr_sat;
    logic signed [DATA_W-1:0]  out_sat;
`ifdef DELAY_CLEAR_EN
    logic        [ADDR_W:0]    clr_cnt;
`endif

    // Gain is unsigned, so it enters the signed multiply with a zero sign bit.
    assign prod = PROD_W'(d_q) * PROD_W'($signed({1'b0, gain_q}));
    assign fbp  = (WORD_W+1)'(prod >>> FB_W);
    assign sum  = (WORD_W+2)'(in_q) + (WORD_W+2)'(fbp);

    delay_sat #(.IN_W(WORD_W+2), .OUT_W(WORD_W)) u_sat_wr (
        .din  (sum),
        .dout (wr_sat)
    );

    delay_sat #(.IN_W(WORD_W), .OUT_W(DATA_W)) u_sat_out (
        .din  (d_q),
        .dout (out_sat)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
`ifdef DELAY_CLEAR_EN
            state   <= ST_CLEAR;
            clr_cnt <= '0;
`else
            state   <= ST_IDLE;
`endif
            wr_ptr     <= '0;
            in_q       <= '0;
            gain_q     <= '0;
            d_q        <= '0;
            MEM_ADDR   <= '0;
            MEM_DI     <= '0;
            MEM_WE     <= 1'b0;
            OUT_SAMPLE <= '0;
            OUT_VALID  <= 1'b0;
            BUSY       <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            MEM_WE    <= 1'b0;
            OUT_VALID <= 1'b0;
            if (SAMPLE_STB && state != ST_IDLE)
                OVERRUN <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (SAMPLE_STB) begin
                        in_q     <= IN_SAMPLE;
                        gain_q   <= FB_GAIN;
                        MEM_ADDR <= wr_ptr - DELAY_LEN;
                        BUSY     <= 1'b1;
                        state    <= ST_RD;
                    end
                end
                ST_RD:  state <= ST_CAP;
                ST_CAP: begin
                    d_q   <= $signed(MEM_DO);
                    state <= ST_MUL;
                end
                // Write data is formed from this cycle's product and lands with MEM_WE in WR.
                ST_MUL: begin
                    MEM_ADDR <= wr_ptr;
                    MEM_DI   <= wr_sat;
                    MEM_WE   <= 1'b1;
                    state    <= ST_WR;
                end
                ST_WR: begin
                    OUT_SAMPLE <= out_sat;
                    OUT_VALID  <= 1'b1;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                    BUSY   <= 1'b0;
                    state  <= ST_IDLE;
                end
`ifdef DELAY_CLEAR_EN
                ST_CLEAR: begin
                    if (clr_cnt[ADDR_W]) begin
                        clr_cnt <= '0;
                        BUSY    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        MEM_ADDR <= clr_cnt[ADDR_W-1:0];
                        MEM_DI   <= '0;
                        MEM_WE   <= 1'b1;
                        BUSY     <= 1'b1;
                        clr_cnt  <= clr_cnt + (ADDR_W+1)'(1);
                    end
                end
`endif
                default: begin
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
